// File: rtl/pipe_pkg.sv
// Shared constants and FSM encoding for the MIPS pipeline MEM stage.
package pipe_pkg;

  localparam int DATA_W          = 32;
  localparam int REG_W           = 5;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    ABORTED = 2'd2
  } mem_state_e;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/pipemwreg.sv
// MEM/WB pipeline register; inserts a bubble while the MEM stage is stalled or aborted.
module pipemwreg
  import pipe_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              bubble,
  input  logic              squash,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [REG_W-1:0]  mrn,
  input  logic [DATA_W-1:0] malu,
  input  logic [DATA_W-1:0] mo,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [REG_W-1:0]  wrn,
  output logic [DATA_W-1:0] walu,
  output logic [DATA_W-1:0] wmo
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || bubble) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wrn    <= '0;
      walu   <= '0;
      wmo    <= '0;
    end else begin
      // A misaligned access still retires, but must not write the register file.
      wwreg  <= mwreg & ~squash;
      wm2reg <= mm2reg;
      wrn    <= mrn;
      walu   <= malu;
      wmo    <= mo;
    end
  end

endmodule

// File: rtl/pipemem_stage.sv
// EXE/MEM register and MEM stage with a req/ack data-memory port and upstream stall.
// Optional access timeout is compiled in with `define PIPEMEM_TIMEOUT_EN.
module pipemem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] ealu,
  input  logic [DATA_W-1:0] eb,
  input  logic [REG_W-1:0]  ern,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  output logic [DATA_W-1:0] malu,
  output logic [REG_W-1:0]  mrn,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [DATA_W-1:0] wmo,
  output logic [DATA_W-1:0] walu,
  output logic [REG_W-1:0]  wrn,
  output logic              misalign,
  output logic              timeout_err
);

  logic [DATA_W-1:0] mb;
  logic              mwmem;
  mem_state_e        state, state_nxt;
  logic              is_mem, memop, timeout_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      malu   <= '0;
      mb     <= '0;
      mrn    <= '0;
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
    end else if (!mem_stall) begin
      malu   <= ealu;
      mb     <= eb;
      mrn    <= ern;
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      mwmem  <= ewmem;
    end
  end

  assign is_mem     = mm2reg | mwmem;
  assign memop      = is_mem & word_aligned(malu[1:0]);
  assign misalign   = is_mem & ~word_aligned(malu[1:0]);
  assign dmem_req   = memop & (state != ABORTED);
  assign dmem_we    = mwmem;
  assign dmem_addr  = malu;
  assign dmem_wdata = mb;
  // A same-cycle ack completes the access without freezing the pipeline.
  assign mem_stall  = dmem_req & ~dmem_ack;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: default next-state assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dmem_req && !dmem_ack) state_nxt = BUSY;
      BUSY: begin
        if (dmem_ack)         state_nxt = IDLE;
        else if (timeout_hit) state_nxt = ABORTED;
      end
      ABORTED: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PIPEMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Counts stalled cycles of the current access, including the first request cycle.
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset || !mem_stall) wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout_hit = (state == BUSY) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset)                     timeout_err <= 1'b0;
    else if (state_nxt == ABORTED) timeout_err <= 1'b1;
  end
`else
  logic cfg_unused;
  assign cfg_unused  = |TIMEOUT;
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  pipemwreg u_mwreg (
    .clock  (clock),
    .reset  (reset),
    .bubble (mem_stall | (state == ABORTED)),
    .squash (misalign),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .mrn    (mrn),
    .malu   (malu),
    .mo     ((dmem_req && dmem_ack) ? dmem_rdata : '0),
    .wwreg  (wwreg),
    .wm2reg (wm2reg),
    .wrn    (wrn),
    .walu   (walu),
    .wmo    (wmo)
  );

endmodule

// File: tb/tb_pipemem_stage.sv
// Randomized scoreboard bench for pipemem_stage with a behavioural memory and pipeline model.
module tb_pipemem_stage;

  localparam int TIMEOUT_TB = 4;
  localparam int N_RANDOM   = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ealu = '0, eb = '0;
  logic [4:0]  ern = '0;
  logic        ewreg = 1'b0, em2reg = 1'b0, ewmem = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;

  logic [31:0] malu, dmem_addr, dmem_wdata, wmo, walu;
  logic [4:0]  mrn, wrn;
  logic        mwreg, mm2reg, dmem_req, dmem_we, mem_stall;
  logic        wwreg, wm2reg, misalign, timeout_err;

  pipemem_stage #(.TIMEOUT(TIMEOUT_TB)) dut (
    .clock(clock), .reset(reset),
    .ealu(ealu), .eb(eb), .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .malu(malu), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn),
    .misalign(misalign), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    int          lat;
    bit          abort;
  } op_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          lat;
    bit          abort;
  } req_t;

  typedef struct {
    logic [4:0]  rn;
    logic        wreg;
    logic        m2reg;
    bit          chk_m2reg;
    logic [31:0] alu;
    logic [31:0] mo;
    bit          chk_mo;
    int          t;
  } wb_t;

  req_t        rq[$];
  wb_t         sb[$];
  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];
  int          errors = 0, checks = 0, cyc = 0, wait_n = 0;
  bit          chk_en = 1'b0, resp_hold = 1'b0;
  logic        exp_req = 1'b0, exp_stall = 1'b0, exp_mis = 1'b0, exp_terr = 1'b0;
  op_t         prev;
  req_t        cur_req;
  wb_t         cur_wb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mem(input op_t o);
    return o.m2reg || o.wmem;
  endfunction

  function automatic bit aligned_mem(input op_t o);
    return is_mem(o) && (o.alu[1:0] == 2'b00);
  endfunction

  // Cycles an op spends in the M stage before the next op can be captured.
  function automatic int occupancy(input op_t o);
    if (!aligned_mem(o)) return 1;
    if (o.abort)         return TIMEOUT_TB + 1;
    return o.lat + 1;
  endfunction

  function automatic op_t mk(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                             input logic wreg, input logic m2reg, input logic wmem,
                             input int lat, input bit abort);
    op_t o;
    o.alu = alu; o.b = b; o.rn = rn; o.wreg = wreg; o.m2reg = m2reg; o.wmem = wmem;
    o.lat = lat; o.abort = abort;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o = mk('0, '0, '0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    int  k = int'($urandom_range(0, 9));
    o.b   = $urandom;
    o.rn  = 5'($urandom_range(1, 31));
    o.lat = int'($urandom_range(0, 4));
    if (k < 4) begin
      o.alu  = $urandom;
      o.wreg = 1'($urandom_range(0, 1));
    end else begin
      o.alu = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if (k < 7) begin
        o.m2reg = 1'b1; o.wreg = 1'b1;
      end else if (k < 9) begin
        o.wmem = 1'b1;
      end else begin
        o.alu[1:0] = 2'($urandom_range(1, 3));
        o.m2reg    = 1'($urandom_range(0, 1));
        o.wmem     = ~o.m2reg;
        o.wreg     = o.m2reg;
      end
    end
    return o;
  endfunction

  // Presents op o at EXE, walks the previous op through M, then records o's expected retirement.
  task automatic issue(input op_t o);
    req_t        r;
    wb_t         w;
    logic [31:0] mo_exp = '0;
    int          idx = int'(o.alu[7:2]);
    bit          mis = is_mem(o) && (o.alu[1:0] != 2'b00);
    if (aligned_mem(o)) begin
      r.addr = o.alu; r.we = o.wmem; r.wdata = o.b; r.lat = o.lat; r.abort = o.abort;
      rq.push_back(r);
      if (o.m2reg) mo_exp = ref_mem[idx];
      if (o.wmem && !o.abort) ref_mem[idx] = o.b;
    end
    ealu = o.alu; eb = o.b; ern = o.rn; ewreg = o.wreg; em2reg = o.m2reg; ewmem = o.wmem;
    for (int c = 0; c < occupancy(prev); c++) begin
      if (aligned_mem(prev) && !prev.abort) begin
        exp_req   = 1'b1;
        exp_stall = (c < prev.lat);
      end else if (aligned_mem(prev)) begin
        exp_req   = (c < TIMEOUT_TB);
        exp_stall = (c < TIMEOUT_TB);
        if (c == TIMEOUT_TB) exp_terr = 1'b1;
      end else begin
        exp_req   = 1'b0;
        exp_stall = 1'b0;
      end
      exp_mis = is_mem(prev) && (prev.alu[1:0] != 2'b00);
      @(negedge clock);
    end
    if (o.rn != 5'd0 && !o.abort) begin
      w.rn = o.rn; w.wreg = o.wreg && !mis; w.m2reg = o.m2reg; w.chk_m2reg = !mis;
      w.alu = o.alu; w.mo = mo_exp; w.chk_mo = !o.wmem; w.t = cyc + occupancy(o);
      sb.push_back(w);
    end
    prev = o;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Data memory: checks each request cycle and acknowledges after the scheduled wait.
  always @(negedge clock) begin
    if (resp_hold) begin
      dmem_ack = 1'b0;
    end else if (dmem_req) begin
      if (rq.size() == 0) begin
        check("unexpected_req", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0;
      end else begin
        cur_req = rq[0];
        wait_n++;
        check("dmem_addr", dmem_addr, cur_req.addr);
        check("dmem_we", 32'(dmem_we), 32'(cur_req.we));
        if (cur_req.we) check("dmem_wdata", dmem_wdata, cur_req.wdata);
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        if (cur_req.abort && wait_n == TIMEOUT_TB) begin
          void'(rq.pop_front());
          wait_n = 0;
        end else if (!cur_req.abort && wait_n == cur_req.lat + 1) begin
          dmem_ack = 1'b1;
          if (cur_req.we) mem_arr[cur_req.addr[7:2]] = cur_req.wdata;
          else            dmem_rdata = mem_arr[cur_req.addr[7:2]];
          void'(rq.pop_front());
          wait_n = 0;
        end
      end
    end else begin
      dmem_ack   = 1'b1 & 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
    end
  end

  // Monitor: per-cycle control expectations and in-order MEM/WB scoreboard.
  always @(negedge clock) begin
    #1;
    if (chk_en) begin
      check("dmem_req", 32'(dmem_req), 32'(exp_req));
      check("mem_stall", 32'(mem_stall), 32'(exp_stall));
      check("misalign", 32'(misalign), 32'(exp_mis));
      check("timeout_err", 32'(timeout_err), 32'(exp_terr));
      if (wrn !== 5'd0) begin
        if (sb.size() == 0) begin
          check("w_unexpected_wrn", 32'(wrn), 32'd0);
        end else begin
          cur_wb = sb.pop_front();
          check("w_cycle", cyc, cur_wb.t);
          check("wrn", 32'(wrn), 32'(cur_wb.rn));
          check("wwreg", 32'(wwreg), 32'(cur_wb.wreg));
          check("walu", walu, cur_wb.alu);
          if (cur_wb.chk_m2reg) check("wm2reg", 32'(wm2reg), 32'(cur_wb.m2reg));
          if (cur_wb.chk_mo) check("wmo", wmo, cur_wb.mo);
        end
      end else begin
        check("bubble_ctl", 32'({wwreg, wm2reg}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[8] = 32'hDEAD_BEEF;
    ref_mem[8] = 32'hDEAD_BEEF;
    prev = mk('0, '0, '0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_mem_stall", 32'(mem_stall), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_malu", malu, 32'd0);
    check("rst_m_ctl", 32'({mwreg, mm2reg, mrn}), 32'd0);
    check("rst_w_ctl", 32'({wwreg, wm2reg, wrn}), 32'd0);
    check("rst_walu", walu, 32'd0);
    check("rst_wmo", wmo, 32'd0);

    reset  = 1'b0;
    chk_en = 1'b1;
    issue(mk(32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 0, 1'b0));
    issue(mk(32'h20, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 0, 1'b0));
    issue(mk(32'h40, 32'h1234, 5'd5, 1'b0, 1'b0, 1'b1, 3, 1'b0));
    issue(mk(32'h22, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 0, 1'b0));
    issue(mk(32'h40, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1, 1'b0));
    for (int i = 0; i < N_RANDOM; i++) issue(rand_op());

`ifdef PIPEMEM_TIMEOUT_EN
    issue(mk(32'h44, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 0, 1'b1));
`else
    issue(mk(32'h44, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 20, 1'b0));
`endif
    for (int i = 0; i < 10; i++) issue(rand_op());
    for (int i = 0; i < 3; i++) issue(mk('0, '0, '0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
    check("sb_drained", sb.size(), 32'd0);
    check("rq_drained", rq.size(), 32'd0);

    chk_en    = 1'b0;
    resp_hold = 1'b1;
    ealu = 32'h80; eb = '0; ern = 5'd7; ewreg = 1'b1; em2reg = 1'b1; ewmem = 1'b0;
    @(negedge clock);
    check("mid_req_issued", 32'(dmem_req), 32'd1);
    ealu = '0; ern = '0; ewreg = 1'b0; em2reg = 1'b0;
    @(negedge clock);
    check("mid_busy_stall", 32'(mem_stall), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_req", 32'(dmem_req), 32'd0);
    check("mid_rst_stall", 32'(mem_stall), 32'd0);
    check("mid_rst_m", 32'({mwreg, mm2reg, mrn}), 32'd0);
    check("mid_rst_malu", malu, 32'd0);
    check("mid_rst_w", 32'({wwreg, wm2reg, wrn}), 32'd0);
    check("mid_rst_walu", walu, 32'd0);
    check("mid_rst_wmo", wmo, 32'd0);
    check("mid_rst_terr", 32'(timeout_err), 32'd0);
    reset    = 1'b0;
    exp_terr = 1'b0;
    @(negedge clock);
    check("post_rst_req", 32'(dmem_req), 32'd0);
    check("post_rst_stall", 32'(mem_stall), 32'd0);
    resp_hold = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
